// File: rtl/lane_assert_monitor.sv
// Per-lane property monitor: AND / EQ / bounded implication checks on foo and bar,
// with violation pulses, sticky flags, saturating counters and first-failure capture.
module lane_assert_monitor #(
  parameter int unsigned LANES = 11,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DLY_W = 3,
  localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DLY_W-1:0] dly,
  input  logic [LANES-1:0] lane_en,
  input  logic [LANES-1:0] foo,
  input  logic [LANES-1:0] bar,
  input  logic             clear,
  output logic [LANES-1:0] viol,
  output logic [LANES-1:0] sticky,
  output logic             any_err,
  output logic             first_valid,
  output logic [SEL_W-1:0] first_lane,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_EQ   = 2'd1;
  localparam logic [1:0] MODE_IMPL = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [1:0]       mode_q;
  logic [0:0]       state_q [LANES];
  logic [0:0]       state_d [LANES];
  logic [DLY_W-1:0] timer_q [LANES];
  logic [DLY_W-1:0] timer_d [LANES];
  logic [CNT_W-1:0] cnt_q   [LANES];
  logic [CNT_W-1:0] cnt_d   [LANES];
  logic [LANES-1:0] viol_q, viol_d;
  logic [LANES-1:0] sticky_q, sticky_d;
  logic             any_err_q, any_err_d;
  logic             first_valid_q, first_valid_d;
  logic [SEL_W-1:0] first_lane_q, first_lane_d;

  logic             mode_chg;
  logic [DLY_W-1:0] arm_val;
  logic [LANES-1:0] fail;

  // Per-lane property evaluation and implication FSMs
  always_comb begin
    mode_chg = (mode != mode_q);
    arm_val  = (dly == '0) ? DLY_W'(1) : dly;
    fail     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      state_d[i] = ST_IDLE;
      timer_d[i] = timer_q[i];
      if (!clear && lane_en[i] && !mode_chg) begin
        case (mode)
          MODE_AND: fail[i] = !(foo[i] && bar[i]);
          MODE_EQ:  fail[i] = (foo[i] != bar[i]);
          MODE_IMPL: begin
            if (state_q[i] == ST_IDLE) begin
              if (foo[i]) begin
                state_d[i] = ST_WAIT;
                timer_d[i] = arm_val;
              end
            end else if (bar[i]) begin
              if (foo[i]) begin
                state_d[i] = ST_WAIT;
                timer_d[i] = arm_val;
              end
            end else if (timer_q[i] > DLY_W'(1)) begin
              state_d[i] = ST_WAIT;
              timer_d[i] = timer_q[i] - DLY_W'(1);
            end else begin
              fail[i] = 1'b1;
              if (foo[i]) begin
                state_d[i] = ST_WAIT;
                timer_d[i] = arm_val;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status: pulses, sticky flags, saturating counters, first-failure capture
  always_comb begin
    viol_d        = fail;
    sticky_d      = clear ? '0 : (sticky_q | fail);
    any_err_d     = |sticky_d;
    first_valid_d = first_valid_q;
    first_lane_d  = first_lane_q;
    for (int i = 0; i < int'(LANES); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (fail[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    if (clear) begin
      first_valid_d = 1'b0;
      first_lane_d  = '0;
    end else if (!first_valid_q && (|fail)) begin
      first_valid_d = 1'b1;
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
        if (fail[i]) first_lane_d = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= '0;
      state_q       <= '{default: ST_IDLE};
      timer_q       <= '{default: '0};
      cnt_q         <= '{default: '0};
      viol_q        <= '0;
      sticky_q      <= '0;
      any_err_q     <= 1'b0;
      first_valid_q <= 1'b0;
      first_lane_q  <= '0;
    end else begin
      mode_q        <= mode;
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      viol_q        <= viol_d;
      sticky_q      <= sticky_d;
      any_err_q     <= any_err_d;
      first_valid_q <= first_valid_d;
      first_lane_q  <= first_lane_d;
    end
  end

  // Counter read port; out-of-range selects read as zero
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_out = cnt_q[i];
    end
  end

  assign viol        = viol_q;
  assign sticky      = sticky_q;
  assign any_err     = any_err_q;
  assign first_valid = first_valid_q;
  assign first_lane  = first_lane_q;

endmodule
